// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command queue: FSM state encoding and data width.
package spi_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4,
        PUSH  = 3'd5
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags; head reads as zero when empty.
module spi_sync_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
    logic             full_reg, empty_reg;
    logic             do_push, do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
        if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    // Flags are computed from the next pointers so they are registered yet current.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            full_reg   <= (wr_ptr_next - rd_ptr_next) == (AW+1)'(DEPTH);
            empty_reg  <= wr_ptr_next == rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

    assign rdata = empty_reg ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign full  = full_reg;
    assign empty = empty_reg;
    assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/spi_cmd_queue.sv
// Command queue and transfer sequencer in front of the SPI shift engine.
// Optional feature: define SPI_CMDQ_TIMEOUT_EN to abort transfers whose done never arrives.
import spi_pkg::*;

module spi_cmd_queue #(
    parameter  int DEPTH    = 4,
    parameter  int NSLV     = 2,
    parameter  int CS_SETUP = 2,
    parameter  int TIMEOUT  = 64,
    localparam int SW       = (NSLV > 1) ? $clog2(NSLV) : 1,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SW-1:0]     cmd_slave,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [NSLV-1:0]   cs_n,
    output logic              xfer_start,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_busy,
    input  logic              xfer_done,
    input  logic [DATA_W-1:0] xfer_rx,
    output logic [CW-1:0]     cmd_count
);

    localparam int SCW = $clog2(CS_SETUP) + 1;

    state_t               state_reg, state_next;
    logic [SW-1:0]        slave_reg, slave_next;
    logic [DATA_W-1:0]    data_reg, data_next;
    logic [DATA_W-1:0]    rx_reg, rx_next;
    logic [SCW-1:0]       setup_reg, setup_next;
    logic                 err_reg, err_next;

    logic                 cmd_full, cmd_empty, cmd_pop;
    logic [SW+DATA_W-1:0] cmd_head;
    logic                 rsp_full, rsp_empty, rsp_push;
    logic [DATA_W:0]      rsp_head;
    logic [CW-1:0]        unused_rsp_count;
    logic                 unused_cfg;

    spi_sync_fifo #(.WIDTH(SW + DATA_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata ({cmd_slave, cmd_data}),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    spi_sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_push),
        .wdata ({err_reg, rx_reg}),
        .pop   (rsp_ready),
        .rdata (rsp_head),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (unused_rsp_count)
    );

    assign unused_cfg = &{1'b0, unused_rsp_count, TIMEOUT[0]};

`ifdef SPI_CMDQ_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT) + 1;
    logic [TCW-1:0] tcnt_reg, tcnt_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            slave_reg <= '0;
            data_reg  <= '0;
            rx_reg    <= '0;
            setup_reg <= '0;
            err_reg   <= 1'b0;
`ifdef SPI_CMDQ_TIMEOUT_EN
            tcnt_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            slave_reg <= slave_next;
            data_reg  <= data_next;
            rx_reg    <= rx_next;
            setup_reg <= setup_next;
            err_reg   <= err_next;
`ifdef SPI_CMDQ_TIMEOUT_EN
            tcnt_reg  <= tcnt_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        slave_next = slave_reg;
        data_next  = data_reg;
        rx_next    = rx_reg;
        setup_next = setup_reg;
        err_next   = err_reg;
        cmd_pop    = 1'b0;
        rsp_push   = 1'b0;
        case (state_reg)
            // Only start a command when its response is guaranteed a slot.
            IDLE: if (!cmd_empty && !rsp_full) begin
                cmd_pop                 = 1'b1;
                {slave_next, data_next} = cmd_head;
                setup_next              = '0;
                err_next                = 1'b0;
                state_next              = SETUP;
            end
            SETUP: begin
                if (setup_reg == SCW'(CS_SETUP - 1)) state_next = START;
                else                                 setup_next = setup_reg + 1'b1;
            end
            START: if (xfer_busy) state_next = WAIT;
            WAIT: if (xfer_done) begin
                rx_next    = xfer_rx;
                state_next = HOLD;
            end
            HOLD: state_next = PUSH;
            PUSH: begin
                rsp_push   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
`ifdef SPI_CMDQ_TIMEOUT_EN
        tcnt_next = '0;
        if (state_reg == START || state_reg == WAIT) begin
            tcnt_next = tcnt_reg + 1'b1;
            if (tcnt_reg == TCW'(TIMEOUT - 1) && !(state_reg == WAIT && xfer_done)) begin
                rx_next    = 8'hFF;
                err_next   = 1'b1;
                state_next = PUSH;
            end
        end
`endif
    end

    logic cs_active;
    assign cs_active = (state_reg == SETUP) || (state_reg == START) ||
                       (state_reg == WAIT)  || (state_reg == HOLD);

    // An out-of-range slave index matches no line, so the transfer runs with CS idle.
    for (genvar gi = 0; gi < NSLV; gi++) begin : g_cs
        assign cs_n[gi] = !(cs_active && slave_reg == SW'(gi));
    end

    assign xfer_start = state_reg == START;
    assign xfer_data  = data_reg;
    assign cmd_ready  = !cmd_full;
    assign rsp_valid  = !rsp_empty;
    assign rsp_data   = rsp_head[DATA_W-1:0];
    // Without the timeout option the stored error bit is always written as 0.
    assign rsp_err    = rsp_head[DATA_W];

endmodule
